// File: rtl/memoria_fifo_ctrl.sv
// Circular-FIFO sequencer for the 16x10 memoria block: pointer/occupancy tracking,
// threshold flags and a sticky overflow/underflow error state.
module memoria_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] wr_add,
  output logic [ADDR_WIDTH-1:0] rd_add,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  valid_out,
  output logic                  error,
  output logic [1:0]            state_dbg
);

  localparam int                  DEPTH_I = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH   = DEPTH_I[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    INICIO = 2'd0,
    ACTIVO = 2'd1,
    ERROR  = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   umbral_alto_reg;
  logic [ADDR_WIDTH:0]   umbral_bajo_reg;
  logic                  active;
  logic                  overflow;
  logic                  underflow;

  // Handshake: push/pop are per-cycle requests with no back-pressure wait; a
  // request is performed only when its wr_en/rd_en is high in that same cycle,
  // and a request that cannot be performed is an overflow/underflow.
  assign active    = (state == ACTIVO);
  assign full      = (count == DEPTH);
  assign empty     = (count == '0);
  assign wr_en     = active & push & ~full;
  assign rd_en     = active & pop & ~empty;
  assign overflow  = active & push & full;
  assign underflow = active & pop & empty;

  assign almost_full  = (count >= umbral_alto_reg);
  assign almost_empty = (count <= umbral_bajo_reg);

  assign wr_add    = wr_ptr;
  assign rd_add    = rd_ptr;
  assign error     = (state == ERROR);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= INICIO;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      umbral_alto_reg <= DEPTH;
      umbral_bajo_reg <= '0;
      valid_out       <= 1'b0;
    end else begin
      // Memory output register loads on the same edge as rd_en, so valid trails by one cycle.
      valid_out <= rd_en;
      case (state)
        INICIO: begin
          umbral_alto_reg <= umbral_alto;
          umbral_bajo_reg <= umbral_bajo;
          state           <= ACTIVO;
        end
        ACTIVO: begin
          if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
          if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
          if (wr_en && !rd_en) begin
            count <= count + CNT_ONE;
          end else if (rd_en && !wr_en) begin
            count <= count - CNT_ONE;
          end
          if (overflow || underflow) state <= ERROR;
        end
        ERROR:   state <= ERROR;
        default: state <= INICIO;
      endcase
    end
  end

endmodule

// File: doc/memoria_fifo_ctrl.md
# memoria_fifo_ctrl

Controller that sequences the 16-entry x 10-bit `memoria` block as a circular FIFO within the transaction layer. It accepts push/pop requests and generates `wr_en`/`rd_en`/`wr_add`/`rd_add` for the memory. It tracks occupancy and produces full/empty/almost-full/almost-empty flags against programmable thresholds. It flags overflow/underflow through a sticky error state.

## Interface
- `ADDR_WIDTH`, 4, memory address width; depth = 2^ADDR_WIDTH = 16.
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `push`  input  1  request to write one word this cycle (data goes straight to memory `data_in`).
- `pop`  input  1  request to read one word this cycle.
- `umbral_alto`  input  ADDR_WIDTH+1  almost-full threshold, latched in INICIO.
- `umbral_bajo`  input  ADDR_WIDTH+1  almost-empty threshold, latched in INICIO.
- `wr_en`  output  1  memory write enable.
- `rd_en`  output  1  memory read enable.
- `wr_add`  output  ADDR_WIDTH  memory write address (write pointer).
- `rd_add`  output  ADDR_WIDTH  memory read address (read pointer).
- `count`  output  ADDR_WIDTH+1  occupancy, 0..16.
- `full`, `empty`, `almost_full`, `almost_empty`  output  1 each  occupancy flags.
- `valid_out`  output  1  `data_out_mem` holds the popped word this cycle.
- `error`  output  1  overflow/underflow occurred; sticky until reset.

## Operation
- **States:** INICIO, ACTIVO, ERROR. `reset` forces INICIO.
- **INICIO:**
  - Lasts exactly one clock after `reset` deasserts.
  - That edge latches `umbral_alto`/`umbral_bajo` into internal registers; next state is ACTIVO.
  - `push`/`pop` are ignored and not flagged.
- **ACTIVO:**
  - Accepted write: `wr_en = push & !full`. Accepted read: `rd_en = pop & !empty`. Both are combinational.
  - Accepted write: `wr_ptr` increments modulo 16 at the edge.
  - Accepted read: `rd_ptr` increments modulo 16 at the edge.
  - `count` changes by +1 on write only, -1 on read only, and is unchanged when both are accepted.
  - `push & full` is overflow and `pop & empty` is underflow. Either one means the offending request is not performed and next state is ERROR.
  - A simultaneous legal request in the same cycle is still performed, e.g. push on full with pop: the pop executes and the push overflows.
- **ERROR:**
  - `wr_en = rd_en = 0`; pointers and `count` are frozen.
  - `error = 1`. The only exit is `reset`.
- **Outputs:**
  - `wr_add = wr_ptr` and `rd_add = rd_ptr`, registered.
  - `full = (count == 16)`, `empty = (count == 0)`.
  - `almost_full = (count >= umbral_alto_reg)`, `almost_empty = (count <= umbral_bajo_reg)`.
  - All flags are combinational from registers.
- **Pointer wrap:** pointers are ADDR_WIDTH bits and wrap from 15 to 0. Full/empty come from `count` only, never from pointer comparison.

## Timing
- **Reset values (asynchronous):**
  - `wr_add = rd_add = 0`, `count = 0`.
  - `full = 0`, `empty = 1`, `almost_full = 0`, `almost_empty = 1`.
  - `wr_en = rd_en = 0`, `valid_out = 0`, `error = 0`.
  - Threshold registers reset to `umbral_alto = 16` and `umbral_bajo = 0`.
- **Write:** the memory captures `data_in` at `wr_add` on the same edge where `wr_en = 1`.
- **Read:**
  - Accepted pop at edge N; `valid_out = 1` during cycle N+1 (registered).
  - `data_out_mem` is valid in that same cycle.
- **Pop the same edge as first push into empty:** the pop is rejected (`empty = 1` that cycle), so it is an underflow and goes to ERROR. Bench must not do this in legal scenarios.
- **Reset mid-operation:** reset takes effect immediately regardless of state.
  - Pending `valid_out` is cleared.
  - Stored memory contents are irrelevant; pointers restart at 0.
- **Flag timing:** flags update in the cycle after the edge that changes `count`.

## Test plan
- **Reset/init:** assert `reset` for 2 cycles, then release with `umbral_alto = 12`, `umbral_bajo = 3`.
  - Expect `empty = 1`, `almost_empty = 1`, `count = 0`, all enables 0.
  - ACTIVO is reached after 1 clock.
- **Fill:** 16 consecutive pushes with data 0x001..0x010.
  - `wr_add` steps 0..15, `count` reaches 16, then `full = 1`.
  - `almost_full` rises when `count = 12`.
  - `almost_empty` falls when `count = 4`.
- **Drain:** 16 consecutive pops.
  - `valid_out` is high 1 cycle after each pop.
  - `data_out_mem` reads 0x001..0x010 in order.
  - `empty = 1` at the end; `error` stays 0.
- **Wrap with simultaneous push+pop:**
  - Preload 10 words, then 20 cycles of push+pop.
  - `count` stays at 10; pointers wrap past 15 to 0.
  - Data order is preserved.
- **Overflow:** fill to 16, then push.
  - `wr_en = 0` that cycle, then `error = 1`.
  - Later push/pop keep `wr_en = rd_en = 0` and `count = 16` until reset.
- **Underflow and mid-op reset:**
  - Pop when empty gives `error = 1`.
  - Separately, assert `reset` mid-burst at `count = 7`: all outputs return to reset values asynchronously, before the next edge.
